// File: rtl/icache_responder_pkg.sv
// Shared widths, constants and state encoding for the instruction cache.
// Keep these aligned with the IF stage and the memory controller.
package icache_responder_pkg;

  localparam int ADDR_W         = 32;
  localparam int INSTR_LEN      = 32;
  localparam int DEF_INDEX_BITS = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] NULL32 = 32'h0000_0000;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [INSTR_LEN-1:0] instr_t;

  // state     | meaning
  // ST_IDLE   | looking up IF requests, hits answered next edge
  // ST_MISS   | one miss outstanding, mem_req held until mem_valid
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

endpackage

// File: rtl/icache_responder_array.sv
// Line storage for the direct-mapped cache: valid bits, tags and data.
// Combinational read port, synchronous write port, valid bits cleared on reset.
module icache_responder_array
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = ADDR_W - DEF_INDEX_BITS - 2,
  parameter int DATA_BITS  = INSTR_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [DATA_BITS-1:0]  o_rd_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_BITS-1:0]  i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [DATA_BITS-1:0] r_data [LINES];

  // Valid bits: cleared by reset so every line is cold afterwards; set on fill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= TRUE;
    end
  end

  // Tag and data payload: no reset needed, guarded by the valid bit.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache between IF and the memory controller.
// One word per line, one outstanding miss; a fill is forwarded to IF only
// if IF is still asking for the missed PC when the word arrives.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rdy,
  input  logic                  i_icache_enable,
  input  logic [ADDR_WIDTH-1:0] i_pc_to_fetch,
  output logic [INSTR_LEN-1:0]  o_instr_fetched,
  output logic                  o_icache_success,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [INSTR_LEN-1:0]  i_mem_data,
  input  logic                  i_mem_valid
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  state_t                  r_state;
  logic                    r_success;
  logic [INSTR_LEN-1:0]    r_instr;
  logic                    r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [ADDR_WIDTH-1:2]   r_miss_addr;

  state_t                  w_state_nxt;
  logic                    w_success_nxt;
  logic [INSTR_LEN-1:0]    w_instr_nxt;
  logic                    w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;
  logic [ADDR_WIDTH-1:2]   w_miss_addr_nxt;
  logic                    w_fill_we;

  logic [ADDR_WIDTH-1:0]   w_pc_aligned;
  logic [INDEX_BITS-1:0]   w_index;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_rd_valid;
  logic [TAG_BITS-1:0]     w_rd_tag;
  logic [INSTR_LEN-1:0]    w_rd_data;
  logic                    w_hit;
  logic                    w_pc_is_miss;
  logic [INDEX_BITS-1:0]   w_fill_index;
  logic [TAG_BITS-1:0]     w_fill_tag;

  // Byte offset bits are don't-care; masking keeps the miss address word aligned.
  assign w_pc_aligned = i_pc_to_fetch & ~(ADDR_WIDTH'(3));
  assign w_index      = w_pc_aligned[INDEX_BITS+1:2];
  assign w_tag        = w_pc_aligned[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit        = w_rd_valid && (w_rd_tag == w_tag);
  assign w_pc_is_miss = (w_pc_aligned[ADDR_WIDTH-1:2] == r_miss_addr);
  assign w_fill_index = r_miss_addr[INDEX_BITS+1:2];
  assign w_fill_tag   = r_miss_addr[ADDR_WIDTH-1:INDEX_BITS+2];

  icache_responder_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (INSTR_LEN)
  ) u_array (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_fill_we),
    .i_wr_index (w_fill_index),
    .i_wr_tag   (w_fill_tag),
    .i_wr_data  (i_mem_data)
  );

  // Next-state and response decode; the success pulse defaults low every cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_success_nxt   = FALSE;
    w_instr_nxt     = r_instr;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_miss_addr_nxt = r_miss_addr;
    w_fill_we       = FALSE;
    case (r_state)
      ST_IDLE: begin
        if (i_icache_enable) begin
          if (w_hit) begin
            w_success_nxt = TRUE;
            w_instr_nxt   = w_rd_data;
          end else begin
            w_mem_req_nxt   = TRUE;
            w_mem_addr_nxt  = w_pc_aligned;
            w_miss_addr_nxt = w_pc_aligned[ADDR_WIDTH-1:2];
            w_state_nxt     = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        // IF requests are not looked up here; only the fill can end the miss.
        if (i_mem_valid) begin
          w_fill_we     = i_rdy;
          w_mem_req_nxt = FALSE;
          w_state_nxt   = ST_IDLE;
          if (i_icache_enable && w_pc_is_miss) begin
            w_success_nxt = TRUE;
            w_instr_nxt   = i_mem_data;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = FALSE;
      end
    endcase
  end

  // State and response registers; everything holds while rdy is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_success   <= FALSE;
      r_instr     <= NULL32;
      r_mem_req   <= FALSE;
      r_mem_addr  <= '0;
      r_miss_addr <= '0;
    end else if (i_rdy) begin
      r_state     <= w_state_nxt;
      r_success   <= w_success_nxt;
      r_instr     <= w_instr_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_miss_addr <= w_miss_addr_nxt;
    end
  end

  assign o_instr_fetched  = r_instr;
  assign o_icache_success = r_success;
  assign o_mem_req        = r_mem_req;
  assign o_mem_addr       = r_mem_addr;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios followed by a
// randomized phase, all compared against a line-address reference model.
module tb_icache_responder;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        success;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;

  int n_checks = 0;
  int n_fail   = 0;

  icache_responder dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_rdy            (rdy),
    .i_icache_enable  (en),
    .i_pc_to_fetch    (pc),
    .o_instr_fetched  (instr),
    .o_icache_success (success),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_data       (mem_data),
    .i_mem_valid      (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each line remembers which word address it holds.
  bit          m_valid [256];
  int unsigned m_word  [256];
  int unsigned m_data  [256];
  bit          m_miss;
  int unsigned m_miss_word;
  logic        e_succ;
  logic [31:0] e_instr;
  logic        e_req;
  logic [31:0] e_addr;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_miss  = 1'b0;
    e_succ  = 1'b0;
    e_instr = 32'h0;
    e_req   = 1'b0;
    e_addr  = 32'h0;
  endtask

  task automatic model_step();
    int unsigned w;
    int unsigned idx;
    if (!rdy) return;
    w   = pc >> 2;
    idx = w % 256;
    e_succ = 1'b0;
    if (!m_miss) begin
      if (en) begin
        if (m_valid[idx] && m_word[idx] == w) begin
          e_succ  = 1'b1;
          e_instr = m_data[idx];
        end else begin
          m_miss      = 1'b1;
          m_miss_word = w;
          e_req       = 1'b1;
          e_addr      = w * 4;
        end
      end
    end else if (mem_valid) begin
      m_valid[m_miss_word % 256] = 1'b1;
      m_word[m_miss_word % 256]  = m_miss_word;
      m_data[m_miss_word % 256]  = mem_data;
      m_miss = 1'b0;
      e_req  = 1'b0;
      if (en && w == m_miss_word) begin
        e_succ  = 1'b1;
        e_instr = mem_data;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("success", {31'b0, success}, {31'b0, e_succ});
    chk("instr", instr, e_instr);
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    chk("mem_addr", mem_addr, e_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; en = 1'b0; pc = 32'h0;
    mem_data = 32'h0; mem_valid = 1'b0;
    model_reset();
    #12;
    chk_all();
    rst_n = 1'b1;

    // Cold miss at 0x0, fill forwarded, then a hit on the refetch.
    en = 1'b1; pc = 32'h0;
    tick();
    tick();
    mem_valid = 1'b1; mem_data = 32'h0000_0093;
    tick();
    chk("fill_fwd", instr, 32'h0000_0093);
    mem_valid = 1'b0;
    tick();
    chk("hit_0", {31'b0, success}, 32'h1);
    en = 1'b0;
    tick();

    // Redirect during a miss: fill completes but is not forwarded.
    en = 1'b1; pc = 32'h100;
    tick();
    pc = 32'h200;
    tick();
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    chk("redirect_nopulse", {31'b0, success}, 32'h0);
    mem_valid = 1'b0; pc = 32'h100;
    tick();
    chk("hit_100", instr, 32'hDEAD_BEEF);
    pc = 32'h200;
    tick();
    chk("miss_200", {31'b0, mem_req}, 32'h1);
    mem_valid = 1'b1; mem_data = 32'h2222_0000;
    tick();
    mem_valid = 1'b0; en = 1'b0;
    tick();

    // Conflict on index 1: 0x004 and 0x404 evict each other.
    en = 1'b1; pc = 32'h004;
    tick();
    mem_valid = 1'b1; mem_data = 32'h1111_1111;
    tick();
    mem_valid = 1'b0; pc = 32'h404;
    tick();
    chk("conflict_miss", mem_addr, 32'h404);
    mem_valid = 1'b1; mem_data = 32'h4444_4444;
    tick();
    mem_valid = 1'b0; pc = 32'h004;
    tick();
    chk("evicted_miss", {31'b0, mem_req}, 32'h1);
    mem_valid = 1'b1; mem_data = 32'h1111_1112;
    tick();
    mem_valid = 1'b0; en = 1'b0;
    tick();

    // rdy low for three cycles while a miss is outstanding.
    en = 1'b1; pc = 32'h300;
    tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    chk("rdy_hold_addr", mem_addr, 32'h300);
    rdy = 1'b1;
    tick();
    mem_valid = 1'b1; mem_data = 32'hCAFE_F00D;
    tick();
    mem_valid = 1'b0;
    tick();
    en = 1'b0;
    tick();

    // Asynchronous reset mid-miss, stray mem_valid afterwards.
    en = 1'b1; pc = 32'h500;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    #2 rst_n = 1'b1; en = 1'b0;
    tick();
    mem_valid = 1'b1; mem_data = 32'h5555_5555;
    tick();
    mem_valid = 1'b0; en = 1'b1; pc = 32'h0;
    tick();
    chk("post_reset_miss", {31'b0, mem_req}, 32'h1);
    mem_valid = 1'b1; mem_data = 32'h0000_0013;
    tick();
    mem_valid = 1'b0; en = 1'b0;
    tick();

    // Randomized traffic over a small set of addresses to force hits and conflicts.
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      en  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0)
        pc = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
      mem_valid = rdy && e_req && ($urandom_range(0, 2) == 0);
      mem_data  = $urandom;
      tick();
    end
    mem_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction cache serving the IF stage's fetch request (enable + PC in, instruction + success pulse out).
- Direct-mapped, one 32-bit instruction per line, one outstanding miss.
- On a miss, fetches the word from the memory controller, fills the line, and returns the word if IF still requests that PC.
- Sits between IF and the memory controller.

Parameters:
- INDEX_BITS, 8, line index width; 2^INDEX_BITS lines.
- ADDR_WIDTH, 32, byte address width.
- TAG_BITS, ADDR_WIDTH-INDEX_BITS-2, tag width (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rdy  input  1  global ready; when low all registers hold.
- icache_enable  input  1  IF fetch request valid (level).
- pc_to_fetch  input  32  fetch byte address; bits [1:0] ignored.
- instr_fetched  output  32  instruction returned to IF.
- icache_success  output  1  one-cycle pulse: instr_fetched is valid for the PC sampled at the response edge.
- mem_req  output  1  miss request to memory controller; held until mem_valid.
- mem_addr  output  32  word-aligned miss address, {pc[31:2],2'b00}.
- mem_data  input  32  fill word from memory.
- mem_valid  input  1  one-cycle pulse: mem_data valid.

Behaviour:
- Reset (rst low, async): state=IDLE; all valid bits 0; icache_success=0; instr_fetched=0; mem_req=0; mem_addr=0.
- rdy low: no register changes, outputs hold. Memory controller is gated by the same rdy and never pulses mem_valid while rdy is low.
- index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; hit = valid[index] && tag_mem[index]==tag.
- States: IDLE, MISS.
- IDLE, icache_enable=0: icache_success<=0.
- IDLE, enable && hit:
  - icache_success<=1, instr_fetched<=data[index].
  - Latency 1 cycle.
  - Back-to-back hits on consecutive cycles give consecutive pulses, each for the PC of the previous edge.
- IDLE, enable && miss:
  - icache_success<=0; mem_req<=1; mem_addr<=word-aligned pc; miss_addr latched; state<=MISS.
- MISS, mem_valid=0:
  - Hold mem_req=1 and mem_addr; icache_success<=0.
  - Requests from IF are ignored (no hit lookup).
- MISS, mem_valid=1:
  - Write tag/data/valid at the miss index; mem_req<=0; state<=IDLE.
  - If icache_enable && pc_to_fetch[31:2]==miss_addr[31:2]: icache_success<=1, instr_fetched<=mem_data.
  - Otherwise (IF redirected or dropped enable): icache_success<=0. The fill still completes; the word is not forwarded.
- A fill to an index with a valid line overwrites it (no victim handling).
- PC change while in MISS (redirect from a mispredicted jump): abandon the response only, as above. IF re-requests, and the new PC is looked up in IDLE.
- instr_fetched holds its last value when success is 0.
- Reset asserted mid-miss: everything returns to reset values immediately; a later stray mem_valid in IDLE is ignored.

Decomposition:
- Shared define file: ADDR (31:0), INSTRLEN (31:0), TRUE/FALSE, NULL32, INDEX_BITS default. Keep them consistent with the IF stage and memory controller.
- Sub-module icache_array: valid/tag/data storage.
  - Combinational read port (index → valid, tag, data).
  - Synchronous write port (we, index, tag, data).
  - Async-reset clear of the valid bits.
- Top: FSM, hit compare, response registers, memory handshake.

Test Plan:
- Reset then enable, pc=0x0000_0000:
  - Cold miss → mem_req=1, mem_addr=0x0 next cycle.
  - mem_valid with mem_data=0x0000_0093 → same edge gives icache_success=1 (one cycle), instr=0x0000_0093.
- Re-request pc=0x0 after fill:
  - Hit → success 1 cycle later, instr=0x0000_0093, mem_req stays 0.
- Miss at pc=0x100, then IF switches pc to 0x200 before mem_valid:
  - Fill returns 0xDEADBEEF → no success pulse.
  - Later pc=0x100 hits with 0xDEADBEEF.
  - pc=0x200 then misses.
- Conflict: fill 0x004 (index 1), then pc=0x404 (same index, different tag):
  - Miss, refill overwrites the line.
  - pc=0x004 then misses again.
- rdy low for 3 cycles during MISS with mem_req=1:
  - mem_req and mem_addr hold, no success.
  - After rdy high, mem_valid completes normally.
- Assert rst low asynchronously mid-MISS:
  - mem_req and success drop immediately, all lines invalid.
  - pc=0x0 misses after release.
